// File: rtl/fsmc_stream_bridge_if.sv
// Bus-side and stream-side signals of the FSMC stream bridge.
// The bus interface / testbench uses the master view, the bridge the slave view.
interface fsmc_stream_bridge_if;
  logic [15:0] module_in;
  logic [2:0]  cs_addr_latch;
  logic        en_cs;
  logic [15:0] module_out;
  logic        cs_state;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output module_in, cs_addr_latch, en_cs, out_ready,
    input  module_out, cs_state, out_data, out_valid
  );

  modport slave (
    input  module_in, cs_addr_latch, en_cs, out_ready,
    output module_out, cs_state, out_data, out_valid
  );
endinterface

// File: rtl/fsmc_stream_bridge.sv
// Register-mapped FSMC slave: four 16-bit registers (CTRL, RATE, TXDATA,
// STATUS). TXDATA words are queued in a FIFO and released on a valid/ready
// stream, with at most one word every RATE+1 cycles.
module fsmc_stream_bridge #(
  parameter logic [2:0] CS_ID = 3'd0,
  parameter int         DEPTH = 16
) (
  input logic               clk,
  input logic               reset,
  fsmc_stream_bridge_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic          en_d, sel, wr;
  logic [3:0]    idx;
  logic          en_bit, ovf;
  logic [15:0]   rate, pace;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [15:0]   rd_mux, module_out_q, status;
  logic          cs_q;
  logic          rise, fall, rise_rd, commit, ctrl_wr, flush, ovf_clr;
  logic          push_req, push, pop, full, empty, valid, hs;

  assign rise     = bus.en_cs & ~en_d;
  assign fall     = ~bus.en_cs & en_d;
  // A read is served at the rise edge, using the live address on module_in.
  assign rise_rd  = rise & (bus.cs_addr_latch == CS_ID) & ~bus.module_in[14];
  // At the fall edge module_in carries the write data.
  assign commit   = fall & sel & wr;
  assign ctrl_wr  = commit & (idx == 4'd0);
  assign flush    = ctrl_wr & bus.module_in[1];
  assign ovf_clr  = ctrl_wr & bus.module_in[2];
  assign push_req = commit & (idx == 4'd2);

  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign push     = push_req & ~full;
  assign valid    = en_bit & ~empty & (pace == 16'd0);
  assign hs       = valid & bus.out_ready;
  // Flush wins over a simultaneous pop so the FIFO always ends up empty.
  assign pop      = hs & ~flush;

  assign status   = {full, empty, ovf, 13'(level)};

  assign bus.module_out = module_out_q;
  assign bus.cs_state   = cs_q;
  assign bus.out_valid  = valid;
  // Gate the head word so the port reads zero whenever nothing is queued.
  assign bus.out_data   = empty ? 16'd0 : mem[rd_ptr];

  // Read-data mux over the register map, indexed by the live address.
  always_comb begin
    rd_mux = 16'd0;
    case (bus.module_in[3:0])
      4'd0:    rd_mux = {15'd0, en_bit};
      4'd1:    rd_mux = rate;
      4'd3:    rd_mux = status;
      default: rd_mux = 16'd0;
    endcase
  end

  // Access framing: edge detect en_cs, latch decode at rise, serve reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_d         <= 1'b0;
      sel          <= 1'b0;
      wr           <= 1'b0;
      idx          <= 4'd0;
      module_out_q <= 16'd0;
      cs_q         <= 1'b0;
    end else begin
      en_d <= bus.en_cs;
      if (rise) begin
        sel <= (bus.cs_addr_latch == CS_ID);
        idx <= bus.module_in[3:0];
        wr  <= bus.module_in[14];
        if (rise_rd) begin
          module_out_q <= rd_mux;
          cs_q         <= 1'b1;
        end
      end else if (fall) begin
        cs_q <= 1'b0;
      end
    end
  end

  // Control registers and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_bit <= 1'b0;
      rate   <= 16'd0;
      ovf    <= 1'b0;
    end else begin
      if (ctrl_wr)
        en_bit <= bus.module_in[0];
      if (commit && idx == 4'd1)
        rate <= bus.module_in;
      // An overflowing push beats a clear in the same cycle.
      if (push_req && full)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  // FIFO pointers and fill level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Pacer: reload on every handshake, otherwise count down to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pace <= 16'd0;
    else if (hs)
      pace <= rate;
    else if (pace != 16'd0)
      pace <= pace - 1'b1;
  end

  // FIFO storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.module_in;
  end
endmodule

// File: tb/tb_fsmc_stream_bridge.sv
// Self-checking bench for fsmc_stream_bridge: register-access table,
// directed stream/overflow/reset sequences, and randomized rounds checked
// against a queue-based model of the FIFO and pacing rules.
module tb_fsmc_stream_bridge;
  localparam int         DEPTH = 16;
  localparam logic [2:0] CS    = 3'd0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fsmc_stream_bridge_if bus();

  fsmc_stream_bridge #(.CS_ID(CS), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          c;
    logic [15:0] d;
  } hs_t;
  hs_t obs[$];

  typedef struct {
    bit          is_wr;
    logic [2:0]  cs;
    logic [3:0]  idx;
    logic [15:0] data;
    logic [15:0] exp_d;
    logic        exp_c;
  } vec_t;
  vec_t tbl[19];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every stream handshake with the cycle it happens on.
  always @(negedge clk)
    if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      obs.push_back('{cyc, bus.out_data});

  task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [2:0] cs, input logic [3:0] idx,
                         output logic [15:0] d, output logic c);
    bus.cs_addr_latch = cs;
    bus.module_in     = {2'b00, 10'd0, idx};
    bus.en_cs         = 1'b1;
    tick();
    d = bus.module_out;
    c = bus.cs_state;
    tick();
    checkv("rd_hold_data", bus.module_out, d);
    bus.en_cs = 1'b0;
    tick();
    checkv("rd_cs_clear", bus.cs_state, 1'b0);
  endtask

  task automatic do_write(input logic [2:0] cs, input logic [3:0] idx, input logic [15:0] data);
    bus.cs_addr_latch = cs;
    bus.module_in     = {2'b01, 10'd0, idx};
    bus.en_cs         = 1'b1;
    tick();
    bus.module_in = data;
    bus.en_cs     = 1'b0;
    tick();
  endtask

  task automatic read_check(input string name, input logic [3:0] idx, input logic [15:0] exp);
    logic [15:0] d;
    logic        c;
    do_read(CS, idx, d, c);
    checkv(name, d, exp);
  endtask

  logic [15:0] rd;
  logic        rc;
  logic [15:0] q[$];
  bit          m_ovf;
  int          rate;

  initial begin
    bus.module_in     = 16'd0;
    bus.cs_addr_latch = 3'd0;
    bus.en_cs         = 1'b0;
    bus.out_ready     = 1'b0;
    reset             = 1'b0;
    repeat (3) tick();
    checkv("rst_module_out", bus.module_out, 16'd0);
    checkv("rst_cs_state", bus.cs_state, 1'b0);
    checkv("rst_out_valid", bus.out_valid, 1'b0);
    checkv("rst_out_data", bus.out_data, 16'd0);
    reset = 1'b1;
    tick();

    // Register access table.
    tbl = '{
      '{1'b0, 3'd0, 4'd3, 16'h0000, 16'h4000, 1'b1},
      '{1'b0, 3'd0, 4'd0, 16'h0000, 16'h0000, 1'b1},
      '{1'b0, 3'd0, 4'd1, 16'h0000, 16'h0000, 1'b1},
      '{1'b1, 3'd0, 4'd1, 16'hBEEF, 16'h0000, 1'b0},
      '{1'b0, 3'd0, 4'd1, 16'h0000, 16'hBEEF, 1'b1},
      '{1'b0, 3'd3, 4'd0, 16'h0000, 16'hBEEF, 1'b0},
      '{1'b1, 3'd3, 4'd1, 16'h5555, 16'h0000, 1'b0},
      '{1'b0, 3'd0, 4'd1, 16'h0000, 16'hBEEF, 1'b1},
      '{1'b1, 3'd0, 4'd0, 16'hFFF9, 16'h0000, 1'b0},
      '{1'b0, 3'd0, 4'd0, 16'h0000, 16'h0001, 1'b1},
      '{1'b1, 3'd0, 4'd0, 16'h0000, 16'h0000, 1'b0},
      '{1'b0, 3'd0, 4'd0, 16'h0000, 16'h0000, 1'b1},
      '{1'b0, 3'd0, 4'd2, 16'h0000, 16'h0000, 1'b1},
      '{1'b1, 3'd0, 4'd3, 16'hFFFF, 16'h0000, 1'b0},
      '{1'b0, 3'd0, 4'd3, 16'h0000, 16'h4000, 1'b1},
      '{1'b1, 3'd0, 4'd7, 16'h1234, 16'h0000, 1'b0},
      '{1'b0, 3'd0, 4'd7, 16'h0000, 16'h0000, 1'b1},
      '{1'b1, 3'd0, 4'd1, 16'h0000, 16'h0000, 1'b0},
      '{1'b0, 3'd0, 4'd1, 16'h0000, 16'h0000, 1'b1}
    };
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].is_wr) begin
        do_write(tbl[i].cs, tbl[i].idx, tbl[i].data);
      end else begin
        do_read(tbl[i].cs, tbl[i].idx, rd, rc);
        checkv($sformatf("tbl%0d_data", i), rd, tbl[i].exp_d);
        checkv($sformatf("tbl%0d_cs", i), rc, tbl[i].exp_c);
      end
    end
    checkv("tbl_no_stream", obs.size(), 0);

    // Three words at RATE=0 drain on consecutive cycles.
    bus.out_ready = 1'b1;
    do_write(CS, 4'd2, 16'h1111);
    do_write(CS, 4'd2, 16'h2222);
    do_write(CS, 4'd2, 16'h3333);
    checkv("en0_no_valid", bus.out_valid, 1'b0);
    checkv("head_visible", bus.out_data, 16'h1111);
    obs.delete();
    do_write(CS, 4'd0, 16'h0001);
    checkv("en1_valid", bus.out_valid, 1'b1);
    repeat (6) tick();
    checkv("r0_count", obs.size(), 3);
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      checkv("r0_data", obs[i].d, 16'h1111 * (i + 1));
      checkv("r0_spacing", obs[i].c - obs[0].c, i);
    end
    checkv("r0_idle", bus.out_valid, 1'b0);

    // RATE=3: handshakes exactly four cycles apart.
    do_write(CS, 4'd0, 16'h0000);
    for (int i = 0; i < 4; i++) do_write(CS, 4'd2, 16'hA0 + 16'(i));
    do_write(CS, 4'd1, 16'd3);
    obs.delete();
    do_write(CS, 4'd0, 16'h0001);
    repeat (20) tick();
    checkv("r3_count", obs.size(), 4);
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      checkv("r3_data", obs[i].d, 16'hA0 + 16'(i));
      if (i > 0) checkv("r3_spacing", obs[i].c - obs[i-1].c, 4);
    end

    // Overflow, OVF_CLR and FLUSH.
    do_write(CS, 4'd0, 16'h0000);
    for (int i = 0; i <= DEPTH; i++) do_write(CS, 4'd2, 16'h0C00 + 16'(i));
    read_check("ovf_status", 4'd3, 16'hA000 | 16'(DEPTH));
    checkv("ovf_head", bus.out_data, 16'h0C00);
    do_write(CS, 4'd0, 16'h0004);
    read_check("ovfclr_status", 4'd3, 16'h8000 | 16'(DEPTH));
    do_write(CS, 4'd0, 16'h0002);
    read_check("flush_status", 4'd3, 16'h4000);

    // A foreign chip-select write to TXDATA has no effect.
    do_write(3'd3, 4'd2, 16'h7777);
    read_check("foreign_status", 4'd3, 16'h4000);

    // Reset in the middle of a TXDATA write.
    read_check("pre_rst_rate", 4'd1, 16'd3);
    bus.cs_addr_latch = CS;
    bus.module_in     = {2'b01, 10'd0, 4'd2};
    bus.en_cs         = 1'b1;
    tick();
    bus.module_in = 16'hDEAD;
    reset = 1'b0;
    #1;
    checkv("async_rst_out", bus.module_out, 16'd0);
    checkv("async_rst_cs", bus.cs_state, 1'b0);
    repeat (2) tick();
    bus.en_cs = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    read_check("post_rst_rate", 4'd1, 16'd0);
    obs.delete();
    do_write(CS, 4'd0, 16'h0001);
    repeat (5) tick();
    checkv("post_rst_no_word", obs.size(), 0);
    read_check("post_rst_status", 4'd3, 16'h4000);

    // Randomized rounds against a queue model.
    for (int r = 0; r < 8; r++) begin
      int n;
      do_write(CS, 4'd0, 16'h0006);
      q.delete();
      m_ovf = 1'b0;
      n = $urandom_range(0, DEPTH + 3);
      for (int i = 0; i < n; i++) begin
        logic [15:0] w;
        w = 16'($urandom);
        do_write(CS, 4'd2, w);
        if (q.size() < DEPTH) q.push_back(w);
        else m_ovf = 1'b1;
        if ($urandom_range(0, 3) == 0) do_write(3'd6, 4'd2, 16'($urandom));
      end
      read_check("rnd_status_fill", 4'd3,
                 {q.size() == DEPTH, q.size() == 0, m_ovf, 13'(q.size())});
      rate = $urandom_range(0, 3);
      do_write(CS, 4'd1, 16'(rate));
      obs.delete();
      do_write(CS, 4'd0, 16'h0001);
      for (int t = 0; t < 1000 && obs.size() < q.size(); t++) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      bus.out_ready = 1'b1;
      repeat (6) tick();
      checkv("rnd_count", obs.size(), q.size());
      for (int i = 0; i < q.size() && i < obs.size(); i++) begin
        checkv("rnd_data", obs[i].d, q[i]);
        if (i > 0) checkv("rnd_min_gap", (obs[i].c - obs[i-1].c) >= rate + 1, 1);
      end
      read_check("rnd_status_drain", 4'd3, {2'b01, m_ovf, 13'd0});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
